// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings and saturating-update helper for the branch predictor.
package bp_pkg;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;
  localparam logic [1:0] CTR_INIT = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    return taken ? ((ctr == CTR_ST) ? CTR_ST : ctr + 2'd1)
                 : ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next-state of one 2-bit direction counter; a fresh allocation starts weak-taken.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  input  logic       hit_i,
  output logic [1:0] ctr_o
);
  assign ctr_o = hit_i ? sat_update(ctr_i, taken_i) : CTR_ALLOC;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters; async lookup, resolution-driven redirect.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        br_pred,
  output logic [31:0] new_pc_pred,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        miss_pred,
  output logic [31:0] new_pc
);
  localparam int TAG_W = 30 - IDX_W;
  logic [IDX_W-1:0] idx, upd_idx;
  logic [TAG_W-1:0] tag, upd_tag;
  logic             hit;
  logic             valid [ENTRIES];
  logic [TAG_W-1:0] tags  [ENTRIES];
  logic [31:0]      tgts  [ENTRIES];
  logic [1:0]       ctrs  [ENTRIES];
  assign idx = pc[IDX_W+1:2];
  assign tag = pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign hit = valid[idx] && tags[idx] == tag;
  assign br_pred = hit && ctrs[idx][1];
  assign new_pc_pred = hit ? tgts[idx] : pc + 32'd4;
  // Redirect depends only on the resolution bus, never on the table.
  assign miss_pred = upd_valid && (upd_taken != upd_pred_taken ||
                                   (upd_taken && upd_target != upd_pred_target));
  assign new_pc = (upd_valid && upd_taken) ? upd_target : upd_pc + 32'd4;
  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic             v_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      tgt_q;
    logic [1:0]       ctr_q, ctr_d;
    logic             upd_hit, we;
    assign upd_hit = v_q && tag_q == upd_tag;
    // Not-taken misses leave the slot alone so they cannot evict a useful entry.
    assign we = upd_valid && upd_idx == IDX_W'(g) && (upd_hit || upd_taken);
    bp_sat_counter u_ctr (
      .ctr_i  (ctr_q),
      .taken_i(upd_taken),
      .hit_i  (upd_hit),
      .ctr_o  (ctr_d)
    );
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q   <= 1'b0;
        tag_q <= '0;
        tgt_q <= '0;
        ctr_q <= CTR_INIT;
      end else if (we) begin
        v_q   <= 1'b1;
        tag_q <= upd_tag;
        tgt_q <= upd_taken ? upd_target : tgt_q;
        ctr_q <= ctr_d;
      end
    end
    assign valid[g] = v_q;
    assign tags[g]  = tag_q;
    assign tgts[g]  = tgt_q;
    assign ctrs[g]  = ctr_q;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_branch_predictor;
  typedef struct {
    string       name;
    bit          res;
    logic        b;
    logic [31:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        br_pred;
  logic [31:0] new_pc_pred;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        miss_pred;
  logic [31:0] new_pc;
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .br_pred        (br_pred),
    .new_pc_pred    (new_pc_pred),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .miss_pred      (miss_pred),
    .new_pc         (new_pc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic        gb;
      logic [31:0] gv;
      e = q.pop_front();
      gb = e.res ? miss_pred : br_pred;
      gv = e.res ? new_pc : new_pc_pred;
      total++;
      if (gb !== e.b || gv !== e.v) begin
        bad++;
        $display("FAIL %s: got %b/%h expected %b/%h", e.name, gb, gv, e.b, e.v);
      end
    end
  end

  task automatic look(input string n, input logic b, input logic [31:0] v);
    q.push_back('{n, 1'b0, b, v});
  endtask

  task automatic res(input string n, input logic b, input logic [31:0] v);
    q.push_back('{n, 1'b1, b, v});
  endtask

  task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg);
    upd_valid = 1'b1;
    upd_pc = p;
    upd_taken = t;
    upd_target = tg;
    upd_pred_taken = pt;
    upd_pred_target = ptg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    pc = 32'h100;
    look("reset_held", 1'b0, 32'h104);
    step();
    reset = 1'b0;
    look("after_reset", 1'b0, 32'h104);
    step();
    // train 0x100, lookup of same index in same cycle sees old contents
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    res("train_miss", 1'b1, 32'h200);
    look("collision_old", 1'b0, 32'h104);
    step();
    look("train_hit", 1'b1, 32'h200);
    step();
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    res("nt_miss", 1'b1, 32'h104);
    look("pre_weaken", 1'b1, 32'h200);
    step();
    look("weakened", 1'b0, 32'h200);
    upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    res("match_taken", 1'b0, 32'h200);
    step();
    look("retrained", 1'b1, 32'h200);
    upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    step();
    look("alias_evicted", 1'b0, 32'h104);
    upd(32'h180, 1'b0, 32'h0, 1'b0, 32'h184);
    res("nt_match", 1'b0, 32'h184);
    step();
    pc = 32'h140;
    look("alias_kept", 1'b1, 32'h300);
    step();
    // saturation at 0x40
    pc = 32'h40;
    for (int i = 0; i < 5; i++) begin
      upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      step();
    end
    look("sat_strong", 1'b1, 32'h80);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
    step();
    look("sat_dec1", 1'b1, 32'h80);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
    step();
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h80);
    step();
    look("ctr_snt", 1'b0, 32'h80);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h80);
    step();
    upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    step();
    look("no_underflow", 1'b0, 32'h80);
    step();
    // misprediction outputs
    upd(32'h80, 1'b0, 32'h0, 1'b1, 32'h88);
    res("dir_miss", 1'b1, 32'h84);
    step();
    upd(32'h80, 1'b1, 32'hA0, 1'b1, 32'h90);
    res("tgt_miss", 1'b1, 32'hA0);
    step();
    upd(32'h80, 1'b1, 32'hA0, 1'b1, 32'hA0);
    res("tgt_match", 1'b0, 32'hA0);
    step();
    upd(32'h80, 1'b0, 32'h0, 1'b0, 32'h90);
    res("nt_tgt_ignored", 1'b0, 32'h84);
    step();
    pc = 32'hFFFF_FFFC;
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
    res("wrap_new_pc", 1'b1, 32'h0);
    look("wrap_pred", 1'b0, 32'h0);
    step();
    upd_pc = 32'h10;
    upd_taken = 1'b1;
    upd_target = 32'h500;
    upd_pred_taken = 1'b0;
    res("idle_upd", 1'b0, 32'h14);
    step();
    // reset mid-run with a coincident write
    pc = 32'h100;
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    step();
    look("pre_reset", 1'b1, 32'h200);
    step();
    upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    reset = 1'b1;
    look("mid_reset", 1'b0, 32'h104);
    step();
    reset = 1'b0;
    look("post_reset", 1'b0, 32'h104);
    step();
    pc = 32'h40;
    look("post_reset_40", 1'b0, 32'h44);
    step();
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
